// File: rtl/alu32_pkg.sv
// Shared definitions for the 32-bit ALU select sequencer.
// Holds the FSM state encoding, the 3-bit select type, op index constants,
// datapath widths and the legal settle-latency bounds.
package alu32_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned CNT_W  = 4;

    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 15;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_OFFER  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam sel_t OP0 = 3'd0;
    localparam sel_t OP1 = 3'd1;
    localparam sel_t OP2 = 3'd2;
    localparam sel_t OP3 = 3'd3;
    localparam sel_t OP4 = 3'd4;
    localparam sel_t OP5 = 3'd5;
    localparam sel_t OP6 = 3'd6;
    localparam sel_t OP7 = 3'd7;

    // One-hot mask bit for a select value.
    function automatic logic [MASK_W-1:0] op_bit(input sel_t s);
        return MASK_W'(1) << s;
    endfunction

endpackage

// File: rtl/alu32_op_sequencer_if.sv
// Bundle between the select sequencer and its environment.
//   request side : start, a_in, b_in, op_mask
//   ALU side     : alu_a, alu_b, sel (to ALU), alu_result (from ALU)
//   result side  : res_valid, res_ready, res_data, res_op
//   status       : busy, done
//   checksum     : only present when ALU_SEQ_CHECKSUM_EN is defined
// master = the sequencer, slave = control logic / ALU / result consumer.
interface alu32_op_sequencer_if;
    import alu32_pkg::*;

    logic              start;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic [MASK_W-1:0] op_mask;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    sel_t              sel;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    sel_t              res_op;
    logic              busy;
    logic              done;
`ifdef ALU_SEQ_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    modport master (
        input  start, a_in, b_in, op_mask, alu_result, res_ready,
        output alu_a, alu_b, sel, res_valid, res_data, res_op, busy, done
`ifdef ALU_SEQ_CHECKSUM_EN
        , output checksum
`endif
    );

    modport slave (
        output start, a_in, b_in, op_mask, alu_result, res_ready,
        input  alu_a, alu_b, sel, res_valid, res_data, res_op, busy, done
`ifdef ALU_SEQ_CHECKSUM_EN
        , input checksum
`endif
    );

endinterface

// File: rtl/alu32_prio_enc.sv
// Lowest-set-bit priority encoder used to pick the next ALU select.
//   vec    : candidate op mask
//   idx_c  : index of the lowest set bit (0 when none)
//   none_c : no bit set
module alu32_prio_enc
    import alu32_pkg::*;
(
    input  logic [MASK_W-1:0] vec,
    output sel_t              idx_c,
    output logic              none_c
);

    // Scan from the top down so the lowest set bit wins last.
    always_comb begin
        idx_c  = '0;
        none_c = 1'b1;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx_c  = SEL_W'(i);
                none_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu32_op_sequencer.sv
// Steps the ALU 8:1 result mux through every op enabled in a captured mask,
// waits LATENCY cycles per op, samples the result and offers it downstream
// on a valid/ready handshake. Ops run in ascending select order.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : alu32_op_sequencer_if.master (request, ALU, result, status)
// Optional feature: define ALU_SEQ_CHECKSUM_EN to add bus.checksum, an XOR
// of every accepted result in the current sweep.
module alu32_op_sequencer
    import alu32_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu32_op_sequencer_if.master  bus
);

    // Out-of-range latencies are clamped into the legal window.
    localparam int unsigned LAT_EFF = (LATENCY < LAT_MIN) ? LAT_MIN :
                                      (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF - 1);

    state_t            state;
    logic [MASK_W-1:0] mask;
    logic [CNT_W-1:0]  cnt;

    logic [MASK_W-1:0] mask_rem_c;
    logic [MASK_W-1:0] enc_vec_c;
    sel_t              enc_idx_c;
    logic              enc_none_c;

    // In IDLE pick the first op from the incoming mask; otherwise the next
    // op from what remains once the current one is retired.
    assign mask_rem_c = mask & ~op_bit(bus.sel);
    assign enc_vec_c  = (state == ST_IDLE) ? bus.op_mask : mask_rem_c;

    alu32_prio_enc u_prio_enc (
        .vec    (enc_vec_c),
        .idx_c  (enc_idx_c),
        .none_c (enc_none_c)
    );

    // Sweep FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            mask          <= '0;
            cnt           <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.sel       <= OP0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_op    <= OP0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
`ifdef ALU_SEQ_CHECKSUM_EN
            bus.checksum  <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        bus.alu_a <= bus.a_in;
                        bus.alu_b <= bus.b_in;
                        bus.busy  <= 1'b1;
`ifdef ALU_SEQ_CHECKSUM_EN
                        bus.checksum <= '0;
`endif
                        if (enc_none_c) begin
                            mask     <= '0;
                            bus.done <= 1'b1;
                            state    <= ST_FINISH;
                        end else begin
                            mask    <= bus.op_mask;
                            bus.sel <= enc_idx_c;
                            state   <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    cnt   <= CNT_LOAD;
                    state <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    if (cnt == '0) begin
                        bus.res_data  <= bus.alu_result;
                        bus.res_op    <= bus.sel;
                        bus.res_valid <= 1'b1;
                        state         <= ST_OFFER;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_OFFER: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        mask          <= mask_rem_c;
`ifdef ALU_SEQ_CHECKSUM_EN
                        bus.checksum  <= bus.checksum ^ bus.res_data;
`endif
                        if (enc_none_c) begin
                            bus.done <= 1'b1;
                            state    <= ST_FINISH;
                        end else begin
                            bus.sel <= enc_idx_c;
                            state   <= ST_ISSUE;
                        end
                    end
                end

                ST_FINISH: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu32_op_sequencer.sv
// Directed bench for alu32_op_sequencer with a result scoreboard.
// Define ALU_SEQ_CHECKSUM_EN to also exercise the checksum output.
module tb_alu32_op_sequencer;
    import alu32_pkg::*;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    alu32_op_sequencer_if sif();

    alu32_op_sequencer #(.LATENCY(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.master)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int hs_cnt = 0;
    exp_t expq[$];

    logic        use_tbl;
    logic [31:0] tbl0, tbl1;

    // ALU model: a fixed op set, or a two-entry table for arbitrary results.
    always_comb begin
        sif.alu_result = 32'h0;
        if (use_tbl) begin
            sif.alu_result = (sif.sel == 3'd0) ? tbl0 : tbl1;
        end else begin
            case (sif.sel)
                3'd0: sif.alu_result = sif.alu_a & sif.alu_b;
                3'd1: sif.alu_result = sif.alu_a | sif.alu_b;
                3'd2: sif.alu_result = sif.alu_a ^ sif.alu_b;
                3'd3: sif.alu_result = sif.alu_a + sif.alu_b;
                3'd4: sif.alu_result = sif.alu_a - sif.alu_b;
                3'd5: sif.alu_result = ~sif.alu_a;
                3'd6: sif.alu_result = sif.alu_a << 1;
                default: sif.alu_result = sif.alu_b;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [31:0] data);
        exp_t e;
        e.op   = op;
        e.data = data;
        expq.push_back(e);
    endtask

    // Monitor: compare every handshake against the scoreboard and check
    // that a stalled result holds still.
    logic        hold = 1'b0;
    logic [31:0] hold_data;
    logic [2:0]  hold_op, hold_sel;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("stall res_data", sif.res_data, hold_data);
                check("stall res_op", 32'(sif.res_op), 32'(hold_op));
                check("stall sel", 32'(sif.sel), 32'(hold_sel));
                check("stall res_valid", 32'(sif.res_valid), 32'd1);
            end
            if (sif.res_valid && sif.res_ready) begin
                hs_cnt++;
                if (expq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected result: op %0d data %h, none expected",
                             sif.res_op, sif.res_data);
                end else begin
                    e = expq.pop_front();
                    check("res_op", 32'(sif.res_op), 32'(e.op));
                    check("res_data", sif.res_data, e.data);
                end
            end
            hold      = sif.res_valid && !sif.res_ready;
            hold_data = sif.res_data;
            hold_op   = sif.res_op;
            hold_sel  = sif.sel;
        end
    end

    // Called #1 after an edge; counts edges from start acceptance to done.
    task automatic wait_done(input int max_cyc, output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < max_cyc) begin
            @(posedge clk); #1;
            sif.start = 1'b0;
            cyc++;
            if (sif.done) got = 1'b1;
        end
    endtask

    task automatic run_sweep(input logic [31:0] a, input logic [31:0] b, input logic [7:0] m,
                             input int exp_cyc, input int exp_hs, input string name);
        int cyc;
        bit got;
        int hs0;
        hs0 = hs_cnt;
        sif.a_in    = a;
        sif.b_in    = b;
        sif.op_mask = m;
        sif.start   = 1'b1;
        wait_done(300, cyc, got);
        check({name, " done seen"}, 32'(got), 32'd1);
        check({name, " done latency"}, 32'(cyc), 32'(exp_cyc));
        check({name, " busy with done"}, 32'(sif.busy), 32'd1);
        @(posedge clk); #1;
        check({name, " done single"}, 32'(sif.done), 32'd0);
        check({name, " busy after"}, 32'(sif.busy), 32'd0);
        check({name, " handshakes"}, 32'(hs_cnt - hs0), 32'(exp_hs));
    endtask

    initial begin
        int cyc;
        bit got;
        int hs0;
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit got;
        int hs0;
        rst_n         = 1'b0;
        sif.start     = 1'b0;
        sif.a_in      = 32'h0;
        sif.b_in      = 32'h0;
        sif.op_mask   = 8'h0;
        sif.res_ready = 1'b1;
        use_tbl       = 1'b0;
        tbl0          = 32'h0;
        tbl1          = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(sif.busy), 32'd0);
        check("reset done", 32'(sif.done), 32'd0);
        check("reset res_valid", 32'(sif.res_valid), 32'd0);
        check("reset sel", 32'(sif.sel), 32'd0);
        check("reset alu_a", sif.alu_a, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single op: a & b = 0
        push(3'd0, 32'h0000_0000);
        run_sweep(32'h0000_00F0, 32'h0000_000F, 8'h01, 4, 1, "mask01");

        // Sparse mask, ascending order
        push(3'd0, 32'h0000_0030);
        push(3'd2, 32'h0000_00CC);
        push(3'd5, 32'hFFFF_FF0F);
        push(3'd7, 32'h0000_003C);
        run_sweep(32'h0000_00F0, 32'h0000_003C, 8'hA5, 13, 4, "maskA5");

        // Empty mask
        run_sweep(32'h0000_00F0, 32'h0000_003C, 8'h00, 1, 0, "mask00");

        // Back-pressure on the first result
        hs0 = hs_cnt;
        sif.res_ready = 1'b0;
        push(3'd0, 32'h0000_0030);
        push(3'd1, 32'h0000_00FC);
        sif.a_in    = 32'h0000_00F0;
        sif.b_in    = 32'h0000_003C;
        sif.op_mask = 8'h03;
        sif.start   = 1'b1;
        cyc = 0;
        while (!sif.res_valid && cyc < 50) begin
            @(posedge clk); #1;
            sif.start = 1'b0;
            cyc++;
        end
        check("stall valid seen", 32'(sif.res_valid), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("stall no accept", 32'(hs_cnt - hs0), 32'd0);
        sif.res_ready = 1'b1;
        wait_done(100, cyc, got);
        check("stall done seen", 32'(got), 32'd1);
        check("stall handshakes", 32'(hs_cnt - hs0), 32'd2);
        @(posedge clk); #1;

        // Reset during SETTLE of op 2
        hs0 = hs_cnt;
        push(3'd0, 32'h0000_0030);
        push(3'd1, 32'h0000_00FC);
        sif.op_mask = 8'hFF;
        sif.start   = 1'b1;
        cyc = 0;
        while (sif.sel != 3'd2 && cyc < 50) begin
            @(posedge clk); #1;
            sif.start = 1'b0;
            cyc++;
        end
        check("rst reach op2", 32'(sif.sel), 32'd2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst alu_a", sif.alu_a, 32'h0);
        check("rst alu_b", sif.alu_b, 32'h0);
        check("rst sel", 32'(sif.sel), 32'd0);
        check("rst res_valid", 32'(sif.res_valid), 32'd0);
        check("rst res_data", sif.res_data, 32'h0);
        check("rst res_op", 32'(sif.res_op), 32'd0);
        check("rst busy", 32'(sif.busy), 32'd0);
        check("rst done", 32'(sif.done), 32'd0);
`ifdef ALU_SEQ_CHECKSUM_EN
        check("rst checksum", sif.checksum, 32'h0);
`endif
        check("rst handshakes", 32'(hs_cnt - hs0), 32'd2);
        check("rst queue drained", 32'(expq.size()), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        push(3'd1, 32'h0000_00FC);
        run_sweep(32'h0000_00F0, 32'h0000_003C, 8'h02, 4, 1, "post-rst mask02");

`ifdef ALU_SEQ_CHECKSUM_EN
        use_tbl = 1'b1;
        tbl0    = 32'h1234_5678;
        tbl1    = 32'hFFFF_0000;
        push(3'd0, 32'h1234_5678);
        push(3'd1, 32'hFFFF_0000);
        run_sweep(32'h0, 32'h0, 8'h03, 7, 2, "checksum");
        check("checksum value", sif.checksum, 32'hEDCB_5678);
        use_tbl = 1'b0;
`endif

        check("scoreboard empty", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
